// File: rtl/aes_final_pkg.sv
// rtl/aes_final_pkg.sv - S-box table, Rcon lookup, FSM state type and round helpers
package aes_final_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    ADD  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Entry 0 sits in the top byte, so entry b lives at bits [8*(255-b) +: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon_lookup(input logic [3:0] rc);
    logic [7:0] r;
    case (rc)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Byte j is [127-8j -: 8]; row r = bytes r, r+4, r+8, r+12 rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  // sub_rot is SubWord(RotWord(w3)), produced by the caller's S-box lanes.
  function automatic logic [127:0] keystep(input logic [127:0] key,
                                           input logic [31:0]  sub_rot,
                                           input logic [7:0]   rcon);
    logic [31:0] w0, w1, w2, w3;
    w0 = key[127:96] ^ sub_rot ^ {rcon, 24'h0};
    w1 = key[95:64] ^ w0;
    w2 = key[63:32] ^ w1;
    w3 = key[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/sbox_byte.sv
// rtl/sbox_byte.sv - single-byte AES S-box lookup
module sbox_byte
  import aes_final_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] subst
);

  assign subst = sbox_lookup(data);

endmodule

// File: rtl/aes_round_final_engine.sv
// rtl/aes_round_final_engine.sv - handshaked AES final round with lane-serial SubBytes
// AES_FINAL_MODADD_EN selects the per-word modular add with k1 instead of XOR.
module aes_round_final_engine
  import aes_final_pkg::*;
#(
  parameter int unsigned SBOX_LANES   = 4,
  parameter int unsigned ADD_MOD_BITS = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   rc,
  input  logic [127:0] rin,
  input  logic [127:0] keylastin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] fout
);

  localparam int unsigned SUB_CYCLES = 16 / SBOX_LANES;
  localparam logic [3:0]  SUB_LAST   = 4'(SUB_CYCLES - 1);
  localparam logic [31:0] MOD_MASK   = 32'hffff_ffff >> (32 - ADD_MOD_BITS);

  state_t                  state, state_next;
  logic [3:0]              cnt;
  logic [3:0]              rc_q;
  logic [127:0]            rin_q, key_q, sb_q, ma_q, fout_q, ma_next;
  logic                    out_valid_q;
  logic [8*SBOX_LANES-1:0] lane_bus;
  logic [31:0]             k1_rot, k2_rot, k1_sub, k2_sub;
  logic [127:0]            k1, k2;

  // rin_q shifts left as it is consumed, so the lanes always read its top bytes.
  for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
    sbox_byte u_sbox (
      .data  (rin_q[127 - 8*l -: 8]),
      .subst (lane_bus[8*(SBOX_LANES - 1 - l) +: 8])
    );
  end

  assign k1_rot = {key_q[23:0], key_q[31:24]};
  assign k2_rot = {k1[23:0], k1[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_ksub
    sbox_byte u_k1 (.data(k1_rot[8*b +: 8]), .subst(k1_sub[8*b +: 8]));
    sbox_byte u_k2 (.data(k2_rot[8*b +: 8]), .subst(k2_sub[8*b +: 8]));
  end

  assign k1 = keystep(key_q, k1_sub, rcon_lookup(rc_q));
  assign k2 = keystep(k1, k2_sub, rcon_lookup(rc_q));

`ifdef AES_FINAL_MODADD_EN
  always_comb begin
    ma_next = '0;
    for (int i = 0; i < 4; i++) begin
      ma_next[32*i +: 32] = (k1[32*i +: 32] + sb_q[32*i +: 32]) & MOD_MASK;
    end
  end
`else
  logic [31:0] unused_mod_mask;
  assign unused_mod_mask = MOD_MASK;

  always_comb begin
    ma_next = '0;
    ma_next = k1 ^ sb_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SUB;
      SUB:     if (cnt == SUB_LAST) state_next = ADD;
      ADD:     state_next = OUT;
      OUT:     if (out_valid_q && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    in_ready = (state == IDLE);
  end

  assign out_valid = out_valid_q;
  assign fout      = fout_q;

  // fout is loaded on the first OUT cycle; out_valid follows it so both rise together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      rc_q        <= '0;
      rin_q       <= '0;
      key_q       <= '0;
      sb_q        <= '0;
      ma_q        <= '0;
      fout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rin_q <= rin;
            key_q <= keylastin;
            rc_q  <= rc;
            cnt   <= '0;
          end
        end
        SUB: begin
          rin_q <= rin_q << (8*SBOX_LANES);
          sb_q  <= (sb_q << (8*SBOX_LANES)) | 128'(lane_bus);
          cnt   <= cnt + 4'd1;
        end
        ADD: ma_q <= ma_next;
        OUT: begin
          if (!out_valid_q) begin
            fout_q      <= k2 ^ shift_rows(ma_q);
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_final_engine.sv
// tb/tb_aes_round_final_engine.sv - scoreboard bench driving 4-lane and 16-lane engines in lockstep
// Expectations follow AES_FINAL_MODADD_EN when it is defined for the build.
module tb_aes_round_final_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   rc = '0;
  logic [127:0] rin = '0;
  logic [127:0] keylastin = '0;
  logic [1:0]   in_ready_v, out_valid_v;
  logic [127:0] fout_l4, fout_l16;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc [2];
  logic [1:0] ov_prev = '0;
  logic       rdy_prev = 1'b0;
  logic [127:0] exp0[$];
  logic [127:0] exp1[$];
  logic [7:0]   sbm [256];

`ifdef AES_FINAL_MODADD_EN
  localparam int MODB = 5;
  localparam logic [127:0] ZERO_EXP = 128'h989898cf_fafbfbac_989898cf_fafbfbac;
`else
  localparam logic [127:0] ZERO_EXP = 128'h999898c9_fbfbfbaa_999898c9_fbfbfbaa;
`endif

  aes_round_final_engine #(.SBOX_LANES(4), .ADD_MOD_BITS(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]), .rc(rc),
    .rin(rin), .keylastin(keylastin), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .fout(fout_l4)
  );

  aes_round_final_engine #(.SBOX_LANES(16), .ADD_MOD_BITS(5)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]), .rc(rc),
    .rin(rin), .keylastin(keylastin), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .fout(fout_l16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] m_rcon(input logic [3:0] r);
    logic [7:0] v = 8'h01;
    if (r < 4'd1 || r > 4'd10) return 8'h00;
    for (int i = 1; i < int'(r); i++) v = gmul(v, 8'h02);
    return v;
  endfunction

  function automatic logic [127:0] m_keystep(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] t, s, w0, w1, w2, w3;
    t = k[31:0];
    s = {sbm[t[23:16]], sbm[t[15:8]], sbm[t[7:0]], sbm[t[31:24]]};
    w0 = k[127:96] ^ s ^ {m_rcon(r), 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                         input logic [3:0] r);
    logic [127:0] sb, k1, k2, ma, sr;
    for (int j = 0; j < 16; j++) sb[127 - 8*j -: 8] = sbm[s[127 - 8*j -: 8]];
    k1 = m_keystep(k, r);
    k2 = m_keystep(k1, r);
    for (int i = 0; i < 4; i++) begin
`ifdef AES_FINAL_MODADD_EN
      ma[127 - 32*i -: 32] = 32'((64'(k1[127 - 32*i -: 32]) + 64'(sb[127 - 32*i -: 32]))
                                 & ((64'd1 << MODB) - 64'd1));
`else
      ma[127 - 32*i -: 32] = k1[127 - 32*i -: 32] ^ sb[127 - 32*i -: 32];
`endif
    end
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        sr[127 - 8*(4*c + rr) -: 8] = ma[127 - 8*(4*((c + rr) % 4) + rr) -: 8];
    return k2 ^ sr;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      ov_prev  = '0;
      rdy_prev = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) if (in_valid && in_ready_v[d]) acc_cyc[d] = cyc + 1;
      if (out_valid_v[0] && !ov_prev[0]) chk("lat_l4", 128'(cyc - acc_cyc[0]), 128'(6));
      if (out_valid_v[1] && !ov_prev[1]) chk("lat_l16", 128'(cyc - acc_cyc[1]), 128'(3));
      for (int d = 0; d < 2; d++)
        if (ov_prev[d] && !rdy_prev) chk("ov_hold", 128'(out_valid_v[d]), 128'(1));
      if (out_valid_v[0]) begin
        if (exp0.size() == 0) chk("spurious_l4", 128'(1), 128'(0));
        else if (out_ready) chk("fout_l4", fout_l4, exp0.pop_front());
        else chk("hold_l4", fout_l4, exp0[0]);
      end
      if (out_valid_v[1]) begin
        if (exp1.size() == 0) chk("spurious_l16", 128'(1), 128'(0));
        else if (out_ready) chk("fout_l16", fout_l16, exp1.pop_front());
        else chk("hold_l16", fout_l16, exp1[0]);
      end
      ov_prev  = out_valid_v;
      rdy_prev = out_ready;
    end
  end

  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic [3:0] r,
                      input logic [127:0] e);
    int n = 0;
    while (in_ready_v != 2'b11 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", 128'(in_ready_v), 128'(2'b11));
    rin = s; keylastin = k; rc = r; in_valid = 1'b1;
    exp0.push_back(e);
    exp1.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rand_rdy);
    int n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
    chk("drain", 128'(exp0.size() + exp1.size()), 128'(0));
    out_ready = 1'b1;
    exp0.delete();
    exp1.delete();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s, k;
    logic [3:0]   r;
    int n;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbm[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready_v), 128'(2'b11));
    chk("rst_out_valid", 128'(out_valid_v), 128'(0));
    chk("rst_fout_l4", fout_l4, 128'(0));
    chk("rst_fout_l16", fout_l16, 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // all-zero state and key, rc=1
    send('0, '0, 4'd1, ZERO_EXP);
    n = 0;
    while (!in_ready_v[0] && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("in_ready_low_l4", 128'(n), 128'(7));
    wait_done(0);

    send(rnd128(), rnd128(), 4'd0, '0);
    exp0[0] = model(rin, keylastin, 4'd0);
    exp1[0] = exp0[0];
    wait_done(0);
    send(rnd128(), rnd128(), 4'd15, '0);
    exp0[0] = model(rin, keylastin, 4'd15);
    exp1[0] = exp0[0];
    wait_done(0);

    // output stall with ignored input pulses
    out_ready = 1'b0;
    s = rnd128(); k = rnd128();
    send(s, k, 4'd7, model(s, k, 4'd7));
    n = 0;
    while (out_valid_v != 2'b11 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_ov", 128'(out_valid_v), 128'(2'b11));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      rin = rnd128();
      chk("stall_in_ready", 128'(in_ready_v), 128'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done(0);

    // reset while in SUB drops the transaction
    send(rnd128(), rnd128(), 4'd3, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp0.delete();
    exp1.delete();
    chk("sub_rst_in_ready", 128'(in_ready_v), 128'(2'b11));
    chk("sub_rst_out_valid", 128'(out_valid_v), 128'(0));
    chk("sub_rst_fout_l4", fout_l4, 128'(0));
    chk("sub_rst_fout_l16", fout_l16, 128'(0));
    s = rnd128(); k = rnd128();
    send(s, k, 4'd10, model(s, k, 4'd10));
    wait_done(0);

    for (int v = 0; v < 100; v++) begin
      s = rnd128(); k = rnd128(); r = 4'($urandom_range(0, 15));
      send(s, k, r, model(s, k, r));
      wait_done(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
